// File: rtl/uart_pkg.sv
// Shared UART definitions: default rates, oversampling constants, receiver FSM
// states and the 3-sample majority vote.
package uart_pkg;

   localparam int unsigned CLK_HZ_DEF = 32'd100_000_000;
   localparam int unsigned BAUD_DEF   = 32'd115_200;
   localparam int unsigned OVERSAMPLE = 32'd16;

   // Oversample indices used to vote on each bit; the vote resolves on SAMPLE_C.
   localparam logic [3:0] SAMPLE_A  = 4'd7;
   localparam logic [3:0] SAMPLE_B  = 4'd8;
   localparam logic [3:0] SAMPLE_C  = 4'd9;
   localparam logic [3:0] SCNT_LAST = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: serial line in, byte/handshake/status out.
interface uart_rx_if;

   logic       uart_rx_i;
   logic       uart_rd_i;
   logic [7:0] uart_dat_o;
   logic       uart_valid_o;
   logic       uart_rdy_o;
   logic       uart_frame_err_o;
   logic       uart_overrun_o;

   // Receiver core side.
   modport slave (
      input  uart_rx_i,
      input  uart_rd_i,
      output uart_dat_o,
      output uart_valid_o,
      output uart_rdy_o,
      output uart_frame_err_o,
      output uart_overrun_o
   );

   // Line driver / byte consumer side.
   modport master (
      output uart_rx_i,
      output uart_rd_i,
      input  uart_dat_o,
      input  uart_valid_o,
      input  uart_rdy_o,
      input  uart_frame_err_o,
      input  uart_overrun_o
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Fractional-accumulator tick generator: produces RATE ticks per second on
// average from a CLK_HZ clock, each tick one cycle wide.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEF,
   parameter int unsigned RATE   = OVERSAMPLE * BAUD_DEF
) (
   input  logic sys_clk_i,
   input  logic sys_rst_i,
   input  logic clr_i,
   output logic tick_o
);

   // Wide enough that acc + RATE never overflows before the subtraction.
   localparam int unsigned ACC_W = $clog2(CLK_HZ + RATE);
   localparam logic [ACC_W-1:0] CLK_L  = ACC_W'(CLK_HZ);
   localparam logic [ACC_W-1:0] RATE_L = ACC_W'(RATE);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] sum_s;

   // Next accumulator value before the wrap decision.
   always_comb begin
      sum_s = acc_r + RATE_L;
   end

   // Accumulate, wrap on CLK_HZ and emit a registered tick on each wrap.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         acc_r  <= {ACC_W{1'b0}};
         tick_o <= 1'b0;
      end else if (clr_i) begin
         acc_r  <= {ACC_W{1'b0}};
         tick_o <= 1'b0;
      end else if (sum_s >= CLK_L) begin
         acc_r  <= sum_s - CLK_L;
         tick_o <= 1'b1;
      end else begin
         acc_r  <= sum_s;
         tick_o <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote per bit,
// one-byte holding register with read handshake, framing-error and overrun flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEF,
   parameter int unsigned BAUD   = BAUD_DEF
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   uart_rx_if.slave   bus
);

   logic [1:0]  sync_r;
   logic        rx_s;
   uart_state_t state_r;
   logic [3:0]  scnt_r;
   logic [2:0]  bcnt_r;
   logic [7:0]  shift_r;
   logic [1:0]  samp_r;
   logic        armed_r;
   logic [7:0]  dat_r;
   logic        valid_r;
   logic        rdy_r;
   logic        ferr_r;
   logic        ovr_r;
   logic        tick_s;
   logic        clr_s;
   logic        maj_s;

   assign rx_s = sync_r[1];

   // The accumulator is held at zero in IDLE so the first tick of a frame
   // lands a fixed distance after start detection.
   always_comb begin
      clr_s = (state_r == ST_IDLE);
      maj_s = majority3(samp_r[0], samp_r[1], rx_s);
   end

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ),
      .RATE   (OVERSAMPLE * BAUD)
   ) u_tick (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .clr_i     (clr_s),
      .tick_o    (tick_s)
   );

   // Two-flop synchroniser for the asynchronous line, resetting to idle-high.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], bus.uart_rx_i};
      end
   end

   // Frame FSM with sampling, holding register and status flags.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_r <= ST_IDLE;
         scnt_r  <= 4'd0;
         bcnt_r  <= 3'd0;
         shift_r <= 8'd0;
         samp_r  <= 2'b00;
         armed_r <= 1'b1;
         dat_r   <= 8'd0;
         valid_r <= 1'b0;
         rdy_r   <= 1'b0;
         ferr_r  <= 1'b0;
         ovr_r   <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;

         // A read clears the flags; a same-cycle good stop below overrides it.
         if (bus.uart_rd_i) begin
            rdy_r <= 1'b0;
            ovr_r <= 1'b0;
         end

         if ((state_r != ST_IDLE) && tick_s) begin
            scnt_r <= scnt_r + 4'd1;
            if (scnt_r == SAMPLE_A) samp_r[0] <= rx_s;
            if (scnt_r == SAMPLE_B) samp_r[1] <= rx_s;
         end

         case (state_r)
            ST_IDLE: begin
               // After a framing error the line must be seen high before
               // another start is accepted, so a break reports only once.
               if (rx_s) begin
                  armed_r <= 1'b1;
               end else if (armed_r) begin
                  state_r <= ST_START;
                  scnt_r  <= 4'd0;
               end
            end
            ST_START: begin
               if (tick_s) begin
                  if ((scnt_r == SAMPLE_C) && maj_s) begin
                     state_r <= ST_IDLE;
                  end else if (scnt_r == SCNT_LAST) begin
                     state_r <= ST_DATA;
                     bcnt_r  <= 3'd0;
                  end
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  if (scnt_r == SAMPLE_C) shift_r <= {maj_s, shift_r[7:1]};
                  if (scnt_r == SCNT_LAST) begin
                     if (bcnt_r == 3'd7) state_r <= ST_STOP;
                     bcnt_r <= bcnt_r + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               if (tick_s && (scnt_r == SAMPLE_C)) begin
                  state_r <= ST_IDLE;
                  if (maj_s) begin
                     dat_r   <= shift_r;
                     valid_r <= 1'b1;
                     rdy_r   <= 1'b1;
                     if (rdy_r && !bus.uart_rd_i) ovr_r <= 1'b1;
                  end else begin
                     ferr_r  <= 1'b1;
                     armed_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.uart_dat_o       = dat_r;
   assign bus.uart_valid_o     = valid_r;
   assign bus.uart_rdy_o       = rdy_r;
   assign bus.uart_frame_err_o = ferr_r;
   assign bus.uart_overrun_o   = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. The core runs at 20 MHz / 115200 baud so a
// frame is ~1740 clocks; glitch length and tolerances scale to the same
// fraction of a bit as at 100 MHz.
module tb_uart_rx;

   localparam int CLK_HZ      = 20_000_000;
   localparam int BAUD        = 115_200;
   localparam int BIT_CLKS    = 174;   // 173.6 nominal
   localparam int FAST_CLKS   = 167;   // ~4% fast
   localparam int SLOW_CLKS   = 180;   // ~4% slow
   localparam int GLITCH_CLKS = 40;    // ~0.23 bit
   // Stop-bit vote: 154th tick at clock 1672 after START entry, START entry
   // 3 clocks after the line falls, FSM acts one clock after the tick.
   localparam int RD_COINCIDE = 1675;
   localparam int RD_AFTER    = 1700;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
      logic       rdy;
      logic       ovr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   n_pulse = 0;
   int   pulses_before;
   exp_t exp_q[$];
   exp_t mon_e;

   uart_rx_if bus();

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic rdy, input logic ovr);
      exp_t e;
      e.err = 1'b0; e.data = d; e.rdy = rdy; e.ovr = ovr;
      exp_q.push_back(e);
   endtask

   task automatic expect_ferr(input logic rdy);
      exp_t e;
      e.err = 1'b1; e.data = 8'h00; e.rdy = rdy; e.ovr = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame; optionally pulses uart_rd_i rd_at clocks after the start edge.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk,
                             input int rd_at, input logic end_level);
      @(negedge clk);
      bus.uart_rx_i = 1'b0;
      fork
         begin
            repeat (bclk) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               bus.uart_rx_i = d[i];
               repeat (bclk) @(negedge clk);
            end
            bus.uart_rx_i = stop;
            repeat (bclk) @(negedge clk);
            bus.uart_rx_i = end_level;
         end
         begin
            if (rd_at > 0) begin
               repeat (rd_at) @(negedge clk);
               bus.uart_rd_i = 1'b1;
               @(negedge clk);
               bus.uart_rd_i = 1'b0;
            end
         end
      join
   endtask

   task automatic read_byte(input string name);
      @(negedge clk);
      bus.uart_rd_i = 1'b1;
      @(negedge clk);
      bus.uart_rd_i = 1'b0;
      check({name, "_rdy_after_rd"}, bus.uart_rdy_o, 1'b0);
      check({name, "_ovr_after_rd"}, bus.uart_overrun_o, 1'b0);
   endtask

   task automatic check_drained(input string name);
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: every valid / frame-error pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (bus.uart_valid_o || bus.uart_frame_err_o) begin
         n_pulse++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b dat=%0h, no pulse expected",
                     bus.uart_valid_o, bus.uart_frame_err_o, bus.uart_dat_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_valid", bus.uart_valid_o, !mon_e.err);
            check("pulse_ferr", bus.uart_frame_err_o, mon_e.err);
            if (!mon_e.err) check("pulse_dat", bus.uart_dat_o, mon_e.data);
            check("pulse_rdy", bus.uart_rdy_o, mon_e.rdy);
            check("pulse_ovr", bus.uart_overrun_o, mon_e.ovr);
         end
      end
   end

   initial begin
      bus.uart_rx_i = 1'b1;
      bus.uart_rd_i = 1'b0;
      rst = 1'b1;
      idle(5);
      check("rst_dat", bus.uart_dat_o, 8'h00);
      check("rst_valid", bus.uart_valid_o, 1'b0);
      check("rst_rdy", bus.uart_rdy_o, 1'b0);
      check("rst_ferr", bus.uart_frame_err_o, 1'b0);
      check("rst_ovr", bus.uart_overrun_o, 1'b0);
      rst = 1'b0;
      idle(20);

      // Single frame, then read.
      expect_byte(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, BIT_CLKS, 0, 1'b1);
      idle(100);
      check_drained("a5_drained");
      check("a5_dat", bus.uart_dat_o, 8'hA5);
      check("a5_rdy", bus.uart_rdy_o, 1'b1);
      read_byte("a5");

      // Back-to-back frames, each read by the consumer.
      expect_byte(8'h00, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, BIT_CLKS, RD_AFTER, 1'b1);
      expect_byte(8'hFF, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, BIT_CLKS, RD_AFTER, 1'b1);
      idle(100);
      check_drained("b2b_drained");
      check("b2b_rdy", bus.uart_rdy_o, 1'b0);

      // Short low glitch: false start, no output.
      pulses_before = n_pulse;
      @(negedge clk);
      bus.uart_rx_i = 1'b0;
      idle(GLITCH_CLKS);
      bus.uart_rx_i = 1'b1;
      idle(3 * BIT_CLKS);
      check("glitch_no_pulse", n_pulse, pulses_before);
      expect_byte(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, BIT_CLKS, RD_AFTER, 1'b1);
      idle(100);
      check_drained("glitch_3c_drained");

      // Bad stop bit followed by a 30-bit break: exactly one framing error.
      pulses_before = n_pulse;
      expect_ferr(1'b0);
      send_frame(8'h55, 1'b0, BIT_CLKS, 0, 1'b0);
      idle(30 * BIT_CLKS);
      bus.uart_rx_i = 1'b1;
      idle(2 * BIT_CLKS);
      check("break_one_pulse", n_pulse, pulses_before + 1);
      check("break_rdy", bus.uart_rdy_o, 1'b0);
      check_drained("break_drained");
      expect_byte(8'h81, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1, BIT_CLKS, RD_AFTER, 1'b1);
      idle(100);
      check_drained("after_break_drained");

      // Overrun: two bytes without a read.
      expect_byte(8'h11, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, BIT_CLKS, 0, 1'b1);
      expect_byte(8'h22, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, BIT_CLKS, 0, 1'b1);
      idle(100);
      check("ovr_dat", bus.uart_dat_o, 8'h22);
      check("ovr_flag", bus.uart_overrun_o, 1'b1);
      check("ovr_rdy", bus.uart_rdy_o, 1'b1);
      read_byte("ovr");

      // Read coincident with the second write: write wins, no overrun.
      expect_byte(8'h11, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, BIT_CLKS, 0, 1'b1);
      expect_byte(8'h22, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, BIT_CLKS, RD_COINCIDE, 1'b1);
      idle(100);
      check("coinc_rdy", bus.uart_rdy_o, 1'b1);
      check("coinc_ovr", bus.uart_overrun_o, 1'b0);
      check("coinc_dat", bus.uart_dat_o, 8'h22);
      read_byte("coinc");

      // Baud tolerance.
      expect_byte(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, FAST_CLKS, RD_AFTER, 1'b1);
      idle(100);
      expect_byte(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, SLOW_CLKS, RD_AFTER, 1'b1);
      idle(100);
      check_drained("tol_drained");

      // Reset mid-frame with a byte held.
      expect_byte(8'h96, 1'b1, 1'b0);
      send_frame(8'h96, 1'b1, BIT_CLKS, 0, 1'b1);
      idle(100);
      check("pre_rst_rdy", bus.uart_rdy_o, 1'b1);
      @(negedge clk);
      bus.uart_rx_i = 1'b0;
      idle(3 * BIT_CLKS + 50);
      rst = 1'b1;
      #1;
      check("midrst_dat", bus.uart_dat_o, 8'h00);
      check("midrst_rdy", bus.uart_rdy_o, 1'b0);
      check("midrst_valid", bus.uart_valid_o, 1'b0);
      check("midrst_ferr", bus.uart_frame_err_o, 1'b0);
      check("midrst_ovr", bus.uart_overrun_o, 1'b0);
      bus.uart_rx_i = 1'b1;
      idle(5);
      rst = 1'b0;
      idle(20);
      expect_byte(8'hC3, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, BIT_CLKS, RD_AFTER, 1'b1);
      idle(100);
      check_drained("post_rst_drained");
      check("post_rst_rdy", bus.uart_rdy_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
